// File: rtl/ibex_fetch_aligner.sv
// ibex_fetch_aligner: splits and joins fetch words into decompressed 16/32-bit instructions for ID
module ibex_compressed_decoder (
  input  logic [31:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_instr_o
);
  logic [31:0] i;
  assign i = instr_i;
  always_comb begin
    instr_o = i;
    illegal_instr_o = 1'b0;
    case (i[1:0])
      2'b00: case (i[15:13])
        3'b000: begin
          instr_o = {2'b0, i[10:7], i[12:11], i[5], i[6], 2'b00, 5'h02, 3'b000, 2'b01, i[4:2], 7'h13};
          illegal_instr_o = i[12:5] == 8'b0;
        end
        3'b010: instr_o = {5'b0, i[5], i[12:10], i[6], 2'b00, 2'b01, i[9:7], 3'b010, 2'b01, i[4:2], 7'h03};
        3'b110: instr_o = {5'b0, i[5], i[12], 2'b01, i[4:2], 2'b01, i[9:7], 3'b010, i[11:10], i[6], 2'b00, 7'h23};
        default: illegal_instr_o = 1'b1;
      endcase
      2'b01: case (i[15:13])
        3'b000: instr_o = {{6{i[12]}}, i[12], i[6:2], i[11:7], 3'b0, i[11:7], 7'h13};
        3'b001, 3'b101: instr_o = {i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], {9{i[12]}}, 4'b0, ~i[15], 7'h6f};
        3'b010: instr_o = {{6{i[12]}}, i[12], i[6:2], 5'b0, 3'b0, i[11:7], 7'h13};
        3'b011: begin
          instr_o = (i[11:7] == 5'h02) ?
            {{3{i[12]}}, i[4:3], i[5], i[2], i[6], 4'b0, 5'h02, 3'b000, 5'h02, 7'h13} :
            {{15{i[12]}}, i[6:2], i[11:7], 7'h37};
          illegal_instr_o = {i[12], i[6:2]} == 6'b0;
        end
        3'b100: case (i[11:10])
          2'b00, 2'b01: begin
            instr_o = {1'b0, i[10], 5'b0, i[6:2], 2'b01, i[9:7], 3'b101, 2'b01, i[9:7], 7'h13};
            illegal_instr_o = i[12];
          end
          2'b10: instr_o = {{6{i[12]}}, i[12], i[6:2], 2'b01, i[9:7], 3'b111, 2'b01, i[9:7], 7'h13};
          default: case ({i[12], i[6:5]})
            3'b000: instr_o = {2'b01, 5'b0, 2'b01, i[4:2], 2'b01, i[9:7], 3'b000, 2'b01, i[9:7], 7'h33};
            3'b001: instr_o = {7'b0, 2'b01, i[4:2], 2'b01, i[9:7], 3'b100, 2'b01, i[9:7], 7'h33};
            3'b010: instr_o = {7'b0, 2'b01, i[4:2], 2'b01, i[9:7], 3'b110, 2'b01, i[9:7], 7'h33};
            3'b011: instr_o = {7'b0, 2'b01, i[4:2], 2'b01, i[9:7], 3'b111, 2'b01, i[9:7], 7'h33};
            default: illegal_instr_o = 1'b1;
          endcase
        endcase
        default: instr_o = {{4{i[12]}}, i[6:5], i[2], 5'b0, 2'b01, i[9:7], 2'b00, i[13], i[11:10], i[4:3], i[12], 7'h63};
      endcase
      2'b10: case (i[15:13])
        3'b000: begin
          instr_o = {7'b0, i[6:2], i[11:7], 3'b001, i[11:7], 7'h13};
          illegal_instr_o = i[12];
        end
        3'b010: begin
          instr_o = {4'b0, i[3:2], i[12], i[6:4], 2'b00, 5'h02, 3'b010, i[11:7], 7'h03};
          illegal_instr_o = i[11:7] == 5'b0;
        end
        3'b100: begin
          if (!i[12]) begin
            instr_o = (i[6:2] != 5'b0) ? {7'b0, i[6:2], 5'b0, 3'b0, i[11:7], 7'h33} :
                                         {12'b0, i[11:7], 3'b0, 5'b0, 7'h67};
            illegal_instr_o = i[6:2] == 5'b0 && i[11:7] == 5'b0;
          end else begin
            instr_o = (i[6:2] != 5'b0) ? {7'b0, i[6:2], i[11:7], 3'b0, i[11:7], 7'h33} :
                      (i[11:7] == 5'b0) ? 32'h0010_0073 :
                                          {12'b0, i[11:7], 3'b000, 5'b00001, 7'h67};
          end
        end
        3'b110: instr_o = {4'b0, i[8:7], i[12], i[6:2], 5'h02, 3'b010, i[11:9], 2'b00, 7'h23};
        default: illegal_instr_o = 1'b1;
      endcase
      default: ;
    endcase
  end
endmodule

module ibex_fetch_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_instr_raw_o,
  output logic [31:0] id_pc_o,
  output logic        id_is_compressed_o,
  output logic        id_illegal_c_o,
  output logic        id_err_o
);
  typedef enum logic [1:0] {ALIGNED, UNALIGNED_EMPTY, HELD, ERR} state_t;
  state_t state, nxt;
  logic [15:0] hold_q;
  logic hold_err_q, adv, consume, emit, is_c, err, load_hold, dec_ill;
  logic [2:0] inc;
  logic [31:0] pc_q, raw, dec_instr;
  assign adv = !id_valid_o || id_ready_i;
  assign fetch_ready_o = adv && !branch_i && consume;
  always_comb begin
    nxt = state;
    consume = 1'b0;
    emit = 1'b0;
    is_c = 1'b0;
    err = fetch_err_i;
    load_hold = 1'b0;
    inc = 3'd0;
    raw = fetch_rdata_i;
    case (state)
      ALIGNED: if (fetch_valid_i) begin
        consume = 1'b1;
        emit = 1'b1;
        is_c = fetch_rdata_i[1:0] != 2'b11;
        load_hold = is_c;
        raw = is_c ? {16'b0, fetch_rdata_i[15:0]} : fetch_rdata_i;
        inc = is_c ? 3'd2 : 3'd4;
        nxt = is_c ? HELD : ALIGNED;
      end
      HELD: if (hold_q[1:0] != 2'b11) begin
        emit = 1'b1;
        is_c = 1'b1;
        err = hold_err_q;
        raw = {16'b0, hold_q};
        inc = 3'd2;
        nxt = ALIGNED;
      end else if (fetch_valid_i) begin
        consume = 1'b1;
        emit = 1'b1;
        err = hold_err_q || fetch_err_i;
        raw = {fetch_rdata_i[15:0], hold_q};
        load_hold = 1'b1;
        inc = 3'd4;
      end
      UNALIGNED_EMPTY: if (fetch_valid_i) begin
        consume = 1'b1;
        load_hold = 1'b1;
        nxt = HELD;
      end
      default: ;
    endcase
    if (emit && err) nxt = ERR;
  end
  ibex_compressed_decoder u_dec (.instr_i(raw), .instr_o(dec_instr), .illegal_instr_o(dec_ill));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ALIGNED;
      pc_q <= BOOT_ADDR;
      hold_q <= 16'b0;
      hold_err_q <= 1'b0;
      id_valid_o <= 1'b0;
      id_instr_o <= 32'b0;
      id_instr_raw_o <= 32'b0;
      id_pc_o <= 32'b0;
      id_is_compressed_o <= 1'b0;
      id_illegal_c_o <= 1'b0;
      id_err_o <= 1'b0;
    end else if (branch_i) begin
      state <= branch_addr_i[1] ? UNALIGNED_EMPTY : ALIGNED;
      pc_q <= branch_addr_i & ~32'h1;
      hold_err_q <= 1'b0;
      id_valid_o <= 1'b0;
    end else if (adv) begin
      state <= nxt;
      pc_q <= pc_q + 32'(inc);
      if (load_hold) begin
        hold_q <= fetch_rdata_i[31:16];
        hold_err_q <= fetch_err_i;
      end
      id_valid_o <= emit;
      if (emit) begin
        id_instr_o <= err ? 32'b0 : dec_instr;
        id_instr_raw_o <= err ? 32'b0 : raw;
        id_pc_o <= pc_q;
        id_is_compressed_o <= is_c;
        id_illegal_c_o <= !err && dec_ill;
        id_err_o <= err;
      end
    end
  end
endmodule
